// File: rtl/register_file_32x32_pkg.sv
// Shared constants and types for the PA-RISC general register file.
// REG_IDX_W : width of a register index
// NUM_GR    : number of architectural general registers (GR0..GR31)
// GR_ZERO   : index of the hardwired-zero register
package pa_risc_pkg;

  localparam int unsigned REG_IDX_W          = 5;
  localparam int unsigned NUM_GR             = 32;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  typedef logic [REG_IDX_W-1:0] gr_index_t;

  localparam gr_index_t GR_ZERO = 5'd0;

endpackage : pa_risc_pkg

// File: rtl/register_file_32x32_decoder.sv
// binaryDecoder: 5-to-32 one-hot decoder producing the per-register
// write-select vector.
// Ports:
//   d : binary index to decode
//   e : enable; when low the output is all zeros
//   y : one-hot output, bit d set when e is high
module binaryDecoder
  import pa_risc_pkg::*;
(
  input  logic [REG_IDX_W-1:0] d,
  input  logic                 e,
  output logic [NUM_GR-1:0]    y
);

  always_comb begin
    y = '0;
    if (e) y[d] = 1'b1;
  end

endmodule : binaryDecoder

// File: rtl/register_file_32x32_dff.sv
// reg_dff_en: one register of the file; loads d when ld is high.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low clear
//   ld    : load enable
//   d     : data in
//   q     : stored value
module reg_dff_en #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (ld) q <= d;
  end

endmodule : reg_dff_en

// File: rtl/register_file_32x32.sv
// register_file_32x32: 32-entry general register file, GR0 hardwired to zero,
// one synchronous write port and two combinational read ports with an
// optional write-to-read bypass.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears GR1..GR31, forces reads to 0)
//   we    : write enable
//   rw    : write destination index
//   pw    : write data
//   ra/rb : read indices for ports A/B
//   pa/pb : read data for ports A/B
module register_file_32x32
  import pa_risc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [REG_IDX_W-1:0]  rw,
  input  logic [DATA_WIDTH-1:0] pw,
  input  logic [REG_IDX_W-1:0]  ra,
  input  logic [REG_IDX_W-1:0]  rb,
  output logic [DATA_WIDTH-1:0] pa,
  output logic [DATA_WIDTH-1:0] pb
);

  logic [NUM_GR-1:0]     load;
  logic [DATA_WIDTH-1:0] gr_q [NUM_GR];

  binaryDecoder u_dec (
    .d (rw),
    .e (we),
    .y (load)
  );

  // No storage behind GR0; load[0] is deliberately left unconnected.
  assign gr_q[0] = '0;

  for (genvar n = 1; n < NUM_GR; n++) begin : g_gr
    reg_dff_en #(.WIDTH(DATA_WIDTH)) u_gr (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (load[n]),
      .d     (pw),
      .q     (gr_q[n])
    );
  end

  // Reads are forced to zero during reset, and the bypass is gated too so a
  // pending write cannot leak through while reset is held.
  always_comb begin
    pa = '0;
    if (rst_n && ra != GR_ZERO) begin
      if (BYPASS && we && rw == ra) pa = pw;
      else                          pa = gr_q[ra];
    end
  end

  always_comb begin
    pb = '0;
    if (rst_n && rb != GR_ZERO) begin
      if (BYPASS && we && rw == rb) pb = pw;
      else                          pb = gr_q[rb];
    end
  end

  a_load_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(load));

endmodule : register_file_32x32

// File: tb/tb_register_file_32x32.sv
// Directed testbench for register_file_32x32. Two instances share inputs:
// one with the bypass enabled, one without.
module tb_register_file_32x32;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  rw;
  logic [31:0] pw;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic [31:0] pa1, pb1;  // BYPASS=1
  logic [31:0] pa0, pb0;  // BYPASS=0

  int checks   = 0;
  int failures = 0;

  register_file_32x32 #(.DATA_WIDTH(32), .BYPASS(1'b1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .we(we), .rw(rw), .pw(pw),
    .ra(ra), .rb(rb), .pa(pa1), .pb(pb1)
  );

  register_file_32x32 #(.DATA_WIDTH(32), .BYPASS(1'b0)) dut_nobyp (
    .clk(clk), .rst_n(rst_n), .we(we), .rw(rw), .pw(pw),
    .ra(ra), .rb(rb), .pa(pa0), .pb(pb0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus changes happen on the falling edge; checks follow #1 later.
  task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
    @(negedge clk);
    we = 1'b1; rw = idx; pw = val;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; we = 1'b0; rw = '0; pw = '0; ra = '0; rb = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 32; i += 7) begin
      ra = 5'(i); rb = 5'(31 - i); #1;
      checks++;
      if (pa1 !== 32'h0 || pb1 !== 32'h0 || pa0 !== 32'h0 || pb0 !== 32'h0) begin
        failures++;
        $display("FAIL reset_state idx=%0d got pa=%h pb=%h pa0=%h pb0=%h exp 0", i, pa1, pb1, pa0, pb0);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    write_reg(5'd5, 32'hDEADBEEF);
    ra = 5'd5; #1;
    checks++;
    if (pa1 !== 32'hDEADBEEF || pa0 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL reset_prewrite got pa=%h pa0=%h exp deadbeef", pa1, pa0);
    end
    // Async assert with no clock edge in between.
    #2 rst_n = 1'b0; #1;
    checks++;
    if (pa1 !== 32'h0 || pa0 !== 32'h0) begin
      failures++;
      $display("FAIL reset_async got pa=%h pa0=%h exp 0", pa1, pa0);
    end
    // A write presented while reset is low must be discarded, and blocked
    // from the read path.
    we = 1'b1; rw = 5'd5; pw = 32'hCAFEF00D; #1;
    checks++;
    if (pa1 !== 32'h0 || pa0 !== 32'h0) begin
      failures++;
      $display("FAIL reset_bypass_blocked got pa=%h pa0=%h exp 0", pa1, pa0);
    end
    @(negedge clk); we = 1'b0;
    rst_n = 1'b1; #1;
    checks++;
    if (pa1 !== 32'h0 || pa0 !== 32'h0) begin
      failures++;
      $display("FAIL reset_release got pa=%h pa0=%h exp 0", pa1, pa0);
    end
  endtask

  task automatic test_basic_write;
    write_reg(5'd7, 32'h12345678);
    ra = 5'd7; rb = 5'd7; #1;
    checks++;
    if (pa1 !== 32'h12345678 || pb1 !== 32'h12345678 ||
        pa0 !== 32'h12345678 || pb0 !== 32'h12345678) begin
      failures++;
      $display("FAIL basic_rd7 got pa=%h pb=%h pa0=%h pb0=%h exp 12345678", pa1, pb1, pa0, pb0);
    end
    for (int i = 0; i < 32; i++) begin
      if (i != 7) begin
        ra = 5'(i); rb = 5'(i); #1;
        checks++;
        if (pa1 !== 32'h0 || pb0 !== 32'h0) begin
          failures++;
          $display("FAIL basic_other idx=%0d got pa=%h pb0=%h exp 0", i, pa1, pb0);
        end
      end
    end
  endtask

  task automatic test_gr0;
    @(negedge clk);
    we = 1'b1; rw = 5'd0; pw = 32'hFFFFFFFF; ra = 5'd0; rb = 5'd0; #1;
    checks++;
    if (pa1 !== 32'h0 || pb1 !== 32'h0 || pa0 !== 32'h0) begin
      failures++;
      $display("FAIL gr0_before got pa=%h pb=%h pa0=%h exp 0", pa1, pb1, pa0);
    end
    @(posedge clk); #1;
    checks++;
    if (pa1 !== 32'h0 || pb1 !== 32'h0 || pa0 !== 32'h0) begin
      failures++;
      $display("FAIL gr0_after got pa=%h pb=%h pa0=%h exp 0", pa1, pb1, pa0);
    end
    @(negedge clk); we = 1'b0; #1;
    checks++;
    if (pa1 !== 32'h0 || pa0 !== 32'h0) begin
      failures++;
      $display("FAIL gr0_idle got pa=%h pa0=%h exp 0", pa1, pa0);
    end
  endtask

  task automatic test_bypass;
    write_reg(5'd3, 32'h11);
    @(negedge clk);
    we = 1'b1; rw = 5'd3; pw = 32'h22; ra = 5'd3; rb = 5'd3; #1;
    checks++;
    if (pa1 !== 32'h22 || pb1 !== 32'h22) begin
      failures++;
      $display("FAIL bypass_on_before got pa=%h pb=%h exp 22", pa1, pb1);
    end
    checks++;
    if (pa0 !== 32'h11 || pb0 !== 32'h11) begin
      failures++;
      $display("FAIL bypass_off_before got pa0=%h pb0=%h exp 11", pa0, pb0);
    end
    @(posedge clk); #1; we = 1'b0; #1;
    checks++;
    if (pa1 !== 32'h22 || pa0 !== 32'h22 || pb1 !== 32'h22 || pb0 !== 32'h22) begin
      failures++;
      $display("FAIL bypass_after got pa=%h pa0=%h pb=%h pb0=%h exp 22", pa1, pa0, pb1, pb0);
    end
    // Bypass only on index match: reading GR7 during a GR3 write.
    @(negedge clk);
    we = 1'b1; rw = 5'd3; pw = 32'h33; ra = 5'd7; rb = 5'd3; #1;
    checks++;
    if (pa1 !== 32'h12345678 || pb1 !== 32'h33 || pb0 !== 32'h22) begin
      failures++;
      $display("FAIL bypass_index got pa=%h pb=%h pb0=%h exp 12345678/33/22", pa1, pb1, pb0);
    end
    @(negedge clk); we = 1'b0;
  endtask

  task automatic test_we_hold;
    @(negedge clk);
    we = 1'b0; rw = 5'd9; pw = 32'hAAAA5555; ra = 5'd9; rb = 5'd9;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (pa1 !== 32'h0 || pb0 !== 32'h0) begin
        failures++;
        $display("FAIL we_hold edge=%0d got pa=%h pb0=%h exp 0", i, pa1, pb0);
      end
    end
  endtask

  task automatic test_sweep;
    logic [31:0] exp_a, exp_b;
    for (int n = 1; n < 32; n++) write_reg(5'(n), 32'(n) * 32'h01010101);
    for (int n = 0; n < 32; n++) begin
      ra = 5'(n); rb = 5'(31 - n); #1;
      exp_a = 32'(n) * 32'h01010101;
      exp_b = 32'(31 - n) * 32'h01010101;
      checks++;
      if (pa1 !== exp_a || pb1 !== exp_b || pa0 !== exp_a || pb0 !== exp_b) begin
        failures++;
        $display("FAIL sweep ra=%0d got pa=%h pb=%h pa0=%h pb0=%h exp %h/%h",
                 n, pa1, pb1, pa0, pb0, exp_a, exp_b);
      end
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int n = 0; n < 32; n++) begin
      ra = 5'(n); rb = 5'(n); #1;
      checks++;
      if (pa1 !== 32'h0 || pb0 !== 32'h0) begin
        failures++;
        $display("FAIL reset_mid idx=%0d got pa=%h pb0=%h exp 0", n, pa1, pb0);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic_write;
    test_gr0;
    test_bypass;
    test_we_hold;
    test_sweep;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_register_file_32x32
